// File: rtl/mem_bist.sv
// rtl/mem_bist.sv - write/read-back BIST controller for a single-port synchronous memory.
// Optional second inverted-pattern pass when MEM_BIST_INV_PASS_EN is defined.
module mem_bist #(
  parameter int          ADDR_WIDTH = 4,
  parameter int          DATA_WIDTH = 32,
  parameter logic [31:0] SEED       = 32'hA5A5_0000,
  parameter logic [31:0] STRIDE     = 32'h0101_0101
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_din,
  output logic                  mem_cmd,
  input  logic [DATA_WIDTH-1:0] mem_dout,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [ADDR_WIDTH+1:0] fail_count
);

  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_DRAIN, S_DONE} state_t;

  localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = '0;
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_MAX  = '1;
  localparam logic [ADDR_WIDTH+1:0] CNT_ONE   = (ADDR_WIDTH+2)'(1);
  localparam logic [ADDR_WIDTH+1:0] CNT_MAX   = '1;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [ADDR_WIDTH-1:0]   cmp_addr_q, cmp_addr_d;
  logic [DATA_WIDTH-1:0]   din_q, din_d;
  logic [DATA_WIDTH-1:0]   exp_q, exp_d;
  logic                    cmd_q, cmd_d;
  logic                    cmp_valid_q, cmp_valid_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    pass_q, pass_d;
  logic [ADDR_WIDTH-1:0]   fail_addr_q, fail_addr_d;
  logic [ADDR_WIDTH+1:0]   fail_count_q, fail_count_d;

`ifdef MEM_BIST_INV_PASS_EN
  logic inv_q, inv_d;
`else
  logic inv_q;
  assign inv_q = 1'b0;
`endif

  function automatic logic [DATA_WIDTH-1:0] pattern(input logic [ADDR_WIDTH-1:0] a,
                                                    input logic inv);
    logic [DATA_WIDTH-1:0] p;
    p = DATA_WIDTH'(SEED) + DATA_WIDTH'(a) * DATA_WIDTH'(STRIDE);
    return inv ? ~p : p;
  endfunction

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    cmp_addr_d   = cmp_addr_q;
    din_d        = '0;
    exp_d        = exp_q;
    cmd_d        = 1'b0;
    cmp_valid_d  = 1'b0;
    done_d       = 1'b0;
    pass_d       = pass_q;
    fail_addr_d  = fail_addr_q;
    fail_count_d = fail_count_q;
`ifdef MEM_BIST_INV_PASS_EN
    inv_d        = inv_q;
`endif

    // Compare runs independently of the state so it lands even on the DRAIN exit edge.
    if (cmp_valid_q && (mem_dout != exp_q)) begin
      if (fail_count_q == '0) fail_addr_d = cmp_addr_q;
      if (fail_count_q != CNT_MAX) fail_count_d = fail_count_q + CNT_ONE;
    end

    case (state_q)
      S_IDLE: begin
        addr_d = ADDR_ZERO;
        if (start) begin
          state_d      = S_WRITE;
          pass_d       = 1'b0;
          fail_addr_d  = '0;
          fail_count_d = '0;
          cmd_d        = 1'b1;
          din_d        = pattern(ADDR_ZERO, 1'b0);
`ifdef MEM_BIST_INV_PASS_EN
          inv_d        = 1'b0;
`endif
        end
      end
      S_WRITE: begin
        if (addr_q == ADDR_MAX) begin
          state_d = S_READ;
          addr_d  = ADDR_ZERO;
        end else begin
          addr_d = addr_q + ADDR_ONE;
          cmd_d  = 1'b1;
          din_d  = pattern(addr_d, inv_q);
        end
      end
      S_READ: begin
        exp_d       = pattern(addr_q, inv_q);
        cmp_addr_d  = addr_q;
        cmp_valid_d = 1'b1;
        if (addr_q == ADDR_MAX) state_d = S_DRAIN;
        else                    addr_d  = addr_q + ADDR_ONE;
      end
      S_DRAIN: begin
`ifdef MEM_BIST_INV_PASS_EN
        if (!inv_q) begin
          state_d = S_WRITE;
          inv_d   = 1'b1;
          addr_d  = ADDR_ZERO;
          cmd_d   = 1'b1;
          din_d   = pattern(ADDR_ZERO, 1'b1);
        end else begin
          state_d = S_DONE;
          done_d  = 1'b1;
          pass_d  = (fail_count_d == '0);
        end
`else
        state_d = S_DONE;
        done_d  = 1'b1;
        pass_d  = (fail_count_d == '0);
`endif
      end
      S_DONE: begin
        state_d = S_IDLE;
        addr_d  = ADDR_ZERO;
      end
      default: begin
        state_d = S_IDLE;
        addr_d  = ADDR_ZERO;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      cmp_addr_q   <= '0;
      din_q        <= '0;
      exp_q        <= '0;
      cmd_q        <= 1'b0;
      cmp_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      fail_addr_q  <= '0;
      fail_count_q <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      cmp_addr_q   <= cmp_addr_d;
      din_q        <= din_d;
      exp_q        <= exp_d;
      cmd_q        <= cmd_d;
      cmp_valid_q  <= cmp_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      fail_addr_q  <= fail_addr_d;
      fail_count_q <= fail_count_d;
    end
  end

`ifdef MEM_BIST_INV_PASS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) inv_q <= 1'b0;
    else        inv_q <= inv_d;
  end
`endif

  assign mem_addr   = addr_q;
  assign mem_din    = din_q;
  assign mem_cmd    = cmd_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign fail_addr  = fail_addr_q;
  assign fail_count = fail_count_q;

endmodule

// File: tb/tb_mem_bist.sv
// tb/tb_mem_bist.sv - scoreboard bench for mem_bist with a behavioural 16x32 memory and fault injection.
module tb_mem_bist;
  localparam int AW = 4;
  localparam int DW = 32;
`ifdef MEM_BIST_INV_PASS_EN
  localparam int NP = 2;
`else
  localparam int NP = 1;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din;
  logic          mem_cmd;
  logic [DW-1:0] mem_dout;
  logic          busy, done, pass;
  logic [AW-1:0] fail_addr;
  logic [AW+1:0] fail_count;

  always #5 clk = ~clk;

  mem_bist dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_cmd(mem_cmd), .mem_dout(mem_dout),
    .busy(busy), .done(done), .pass(pass), .fail_addr(fail_addr), .fail_count(fail_count)
  );

  logic [DW-1:0] mem   [16];
  logic [DW-1:0] flip  [16];
  logic [DW-1:0] stuck;

  always @(posedge clk) begin
    if (mem_cmd) mem[mem_addr] <= mem_din;
    else         mem_dout <= (mem[mem_addr] | stuck) ^ flip[mem_addr];
  end

  typedef struct {
    logic          p;
    logic [AW-1:0] fa;
    logic [AW+1:0] fc;
  } res_t;

  res_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  int   e0 = 0;
  bit   run_active = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] pat(input int a);
    return 32'hA5A5_0000 + DW'(a) * 32'h0101_0101;
  endfunction

  function automatic res_t model();
    res_t r;
    logic [DW-1:0] e, rd;
    r.fa = '0;
    r.fc = '0;
    for (int p = 0; p < NP; p++) begin
      for (int a = 0; a < 16; a++) begin
        e  = (p == 1) ? ~pat(a) : pat(a);
        rd = (e | stuck) ^ flip[a];
        if (rd != e) begin
          if (r.fc == '0) r.fa = AW'(a);
          if (r.fc != '1) r.fc = r.fc + 1'b1;
        end
      end
    end
    r.p = (r.fc == '0);
    return r;
  endfunction

  always @(negedge clk) begin
    int   k, b, j;
    res_t r;
    if (run_active) begin
      k = cyc - e0 - 1;
      if (k >= 0) begin
        b = (k >= 33) ? 33 : 0;
        j = k - b;
        if (k < NP * 33 && j < 32) begin
          check_eq("cmd", mem_cmd, (j < 16));
          check_eq("addr", mem_addr, j % 16);
          if (j < 16) check_eq("din", mem_din, (b != 0) ? ~pat(j) : pat(j));
          check_eq("busy", busy, 1);
        end
        if (done) begin
          check_eq("latency", k, NP * 33);
          if (sb_q.size() == 0) check_eq("sb_empty", 1, 0);
          else begin
            r = sb_q.pop_front();
            check_eq("pass", pass, r.p);
            check_eq("fail_addr", fail_addr, r.fa);
            check_eq("fail_count", fail_count, r.fc);
          end
          run_active = 0;
        end else if (k > NP * 33) begin
          check_eq("done_timeout", 0, 1);
          sb_q.delete();
          run_active = 0;
        end
      end
    end else if (done) begin
      check_eq("spurious_done", 1, 0);
    end
  end

  task automatic run(input bit extra_starts);
    res_t r;
    r = model();
    sb_q.push_back(r);
    @(negedge clk);
    start = 1'b1;
    e0 = cyc;
    run_active = 1;
    for (int i = 0; i < 200 && run_active; i++) begin
      @(negedge clk);
      start = (extra_starts && (i == 5 || i == 20)) ? 1'b1 : 1'b0;
    end
    start = 1'b0;
    if (run_active) begin
      check_eq("run_timeout", 0, 1);
      run_active = 0;
      sb_q.delete();
    end
    repeat (3) @(negedge clk);
    check_eq("idle_busy", busy, 0);
    check_eq("pass_hold", pass, r.p);
    check_eq("count_hold", fail_count, r.fc);
  endtask

  initial begin
    for (int a = 0; a < 16; a++) flip[a] = '0;
    stuck = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_pass", pass, 0);
    check_eq("rst_cmd", mem_cmd, 0);
    check_eq("rst_addr", mem_addr, 0);
    check_eq("rst_din", mem_din, 0);
    check_eq("rst_fail_addr", fail_addr, 0);
    check_eq("rst_fail_count", fail_count, 0);
    rst_n = 1'b1;

    run(0);
    flip[5] = 32'h1;
    run(0);
    flip[5] = '0;
    flip[3] = 32'h10;
    flip[9] = 32'h8000_0000;
    run(0);
    flip[3] = '0;
    flip[9] = '0;
    run(0);
    run(1);

    @(negedge clk);
    start = 1'b1;
    e0 = cyc;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    run_active = 0;
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_busy", busy, 0);
    check_eq("arst_cmd", mem_cmd, 0);
    check_eq("arst_addr", mem_addr, 0);
    check_eq("arst_din", mem_din, 0);
    check_eq("arst_count", fail_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    flip[12] = 32'h0000_0400;
    run(0);
    flip[12] = '0;
    run(0);

`ifdef MEM_BIST_INV_PASS_EN
    stuck = 32'h8000_0000;
    run(0);
    stuck = '0;
`endif

    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
